// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths, arbiter FSM states and port IDs.
`timescale 1ns/1ps
package cpu_pkg;

  localparam int CPU_ADDR_W = 16;
  localparam int CPU_DATA_W = 16;

  // Memory-port sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Requester identities, also used to track the round-robin history.
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared memory and the
// arbiter. The arbiter connects through the slave modport; the environment
// (requesters plus memory) uses the master modport.
`timescale 1ns/1ps
interface mem_port_arbiter_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
);

  // Fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  // Load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;

  // Memory side
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Status
  logic              busy;
  logic              err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_done, if_rdata, d_done, d_rdata, mem_addr, mem_we, mem_wdata,
           busy, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_done, if_rdata, d_done, d_rdata, mem_addr, mem_we, mem_wdata,
           busy, err
  );

endinterface

// File: rtl/mem_port_arbiter_req_buf.sv
// One-deep request buffer for a single requester. Holds a pending bit plus the
// latched address/we/wdata, and flags a request that arrives while a previous
// one is still waiting and is not being granted this cycle.
`timescale 1ns/1ps
module mem_req_buf
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_grant,
  output logic              o_pending,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_we,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_overflow
);

  logic              r_pending;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic              w_accept;

  // The buffer is free either when empty or when it is being granted this
  // cycle, so a request on the grant edge is taken without a bubble.
  assign w_accept   = i_req & (~r_pending | i_grant);
  assign o_overflow = i_req & r_pending & ~i_grant;

  // Pending bit and request fields; a dropped request leaves the old fields.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every register samples pre-edge values,
    // independent of statement order inside or across blocks.
    if (reset) begin
      r_pending <= 1'b0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
    end else begin
      r_pending <= (r_pending & ~i_grant) | i_req;
      if (w_accept) begin
        r_addr  <= i_addr;
        r_we    <= i_we;
        r_wdata <= i_wdata;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_addr    = r_addr;
  assign o_we      = r_we;
  assign o_wdata   = r_wdata;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// Round-robin arbitration between the two request buffers, a fixed-latency
// access sequencer, registered memory-side outputs and per-port completion.
`timescale 1ns/1ps
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int DATA_W  = CPU_DATA_W,
  parameter int MEM_LAT = 2           // 1..15 access cycles
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  // Request buffer outputs
  logic              w_if_pend, w_if_we, w_if_ovf;
  logic [ADDR_W-1:0] w_if_addr;
  logic [DATA_W-1:0] w_if_wdata;
  logic              w_d_pend, w_d_we, w_d_ovf;
  logic [ADDR_W-1:0] w_d_addr;
  logic [DATA_W-1:0] w_d_wdata;

  // Arbitration
  logic              w_arb_en, w_gnt_if, w_gnt_d, w_grant, w_last_cyc;
  port_e             w_winner;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_sel_we;
  logic [DATA_W-1:0] w_sel_wdata;

  // State
  state_e            r_state, w_state_nxt;
  logic [3:0]        r_cnt;
  port_e             r_owner, r_last_gnt;
  logic              r_op_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_done, r_d_done;
  logic [DATA_W-1:0] r_if_rdata, r_d_rdata;
  logic              r_err;

  // Fetch never writes, so its write enable is tied low.
  mem_req_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if_buf (
    .clk       (clk),
    .reset     (reset),
    .i_req     (bus.if_req),
    .i_we      (1'b0),
    .i_addr    (bus.if_addr),
    .i_wdata   ('0),
    .i_grant   (w_gnt_if),
    .o_pending (w_if_pend),
    .o_addr    (w_if_addr),
    .o_we      (w_if_we),
    .o_wdata   (w_if_wdata),
    .o_overflow(w_if_ovf)
  );

  mem_req_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_d_buf (
    .clk       (clk),
    .reset     (reset),
    .i_req     (bus.d_req),
    .i_we      (bus.d_we),
    .i_addr    (bus.d_addr),
    .i_wdata   (bus.d_wdata),
    .i_grant   (w_gnt_d),
    .o_pending (w_d_pend),
    .o_addr    (w_d_addr),
    .o_we      (w_d_we),
    .o_wdata   (w_d_wdata),
    .o_overflow(w_d_ovf)
  );

  // Arbitration overlaps DONE so back-to-back accesses lose only one cycle.
  // On a tie the port that was not granted last wins.
  assign w_arb_en    = (r_state == IDLE) || (r_state == DONE);
  assign w_gnt_if    = w_arb_en & w_if_pend & (~w_d_pend  | (r_last_gnt == PORT_D));
  assign w_gnt_d     = w_arb_en & w_d_pend  & (~w_if_pend | (r_last_gnt == PORT_IF));
  assign w_grant     = w_gnt_if | w_gnt_d;
  assign w_winner    = w_gnt_d ? PORT_D : PORT_IF;
  assign w_sel_addr  = w_gnt_d ? w_d_addr  : w_if_addr;
  assign w_sel_we    = w_gnt_d ? w_d_we    : w_if_we;
  assign w_sel_wdata = w_gnt_d ? w_d_wdata : w_if_wdata;
  assign w_last_cyc  = (r_state == ACCESS) && (r_cnt == LAST_CNT);

  // Next-state logic for the access sequencer.
  always_comb begin
    // NOTE: assigning the default first keeps every path driven, so no latch
    // is inferred when a case arm leaves the signal alone.
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_nxt = ACCESS;
      ACCESS:  if (w_last_cyc) w_state_nxt = DONE;
      DONE:    w_state_nxt = w_grant ? ACCESS : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Access-cycle counter, 0..MEM_LAT-1 while in ACCESS, parked at 0 otherwise.
  always_ff @(posedge clk) begin
    if (reset)                   r_cnt <= '0;
    else if (r_state != ACCESS)  r_cnt <= '0;
    else if (w_last_cyc)         r_cnt <= '0;
    else                         r_cnt <= r_cnt + 4'd1;
  end

  // Grant bookkeeping and memory-side outputs; write enable lasts one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_owner     <= PORT_IF;
      r_last_gnt  <= PORT_IF;
      r_op_we     <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_grant) begin
        r_mem_addr  <= w_sel_addr;
        r_mem_we    <= w_sel_we;
        r_mem_wdata <= w_sel_wdata;
        r_owner     <= w_winner;
        r_last_gnt  <= w_winner;
        r_op_we     <= w_sel_we;
      end
    end
  end

  // Completion pulses, read-data capture and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_done  <= 1'b0;
      r_d_done   <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_if_done <= w_last_cyc && (r_owner == PORT_IF);
      r_d_done  <= w_last_cyc && (r_owner == PORT_D);
      if (w_last_cyc && !r_op_we) begin
        if (r_owner == PORT_IF) r_if_rdata <= bus.mem_rdata;
        else                    r_d_rdata  <= bus.mem_rdata;
      end
      r_err <= r_err | w_if_ovf | w_d_ovf;
    end
  end

  assign bus.if_done   = r_if_done;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_done    = r_d_done;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = (r_state != IDLE);
  assign bus.err       = r_err;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single memory port between the instruction-fetch requester and the load/store data requester. It buffers one request per port and arbitrates round-robin when both are pending. It sequences the memory access over a fixed read latency and returns a one-cycle completion pulse with read data to the owning port. It sits between the control unit's fetch/MEM phases and the unified 16-bit memory.

## Interface
- `ADDR_W`, default 16: address width.
- `DATA_W`, default 16: data width.
- `MEM_LAT`, default 2: memory cycles per access.
  - Range 1..15.
  - `mem_rdata` is sampled at the edge ending the MEM_LAT-th access cycle.
  - Async-read RAM = 1; sync-read RAM = 2.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request pulse (one cycle).
- `if_addr`  in  ADDR_W  fetch address, sampled with `if_req`.
- `if_done`  out  1  one-cycle completion pulse to fetch.
- `if_rdata`  out  DATA_W  fetched word; valid from `if_done`, held until the next `if_done`.
- `d_req`  in  1  data request pulse.
- `d_we`  in  1  1 = store, 0 = load; sampled with `d_req`.
- `d_addr`  in  ADDR_W  data address, sampled with `d_req`.
- `d_wdata`  in  DATA_W  store data, sampled with `d_req`.
- `d_done`  out  1  one-cycle completion pulse to data port.
- `d_rdata`  out  DATA_W  load result; valid from `d_done`, held until the next load `d_done`.
- `mem_addr`  out  ADDR_W  memory address (registered).
- `mem_we`  out  1  memory write enable (registered).
- `mem_wdata`  out  DATA_W  memory write data (registered).
- `mem_rdata`  in  DATA_W  memory read data.
- `busy`  out  1  high while state is ACCESS or DONE.
- `err`  out  1  sticky protocol-error flag; cleared only by `reset`.

## Operation
- **Per-port request buffer:** a `pending` bit plus latched address, we and wdata.
  - On a req pulse: `pending` is set and the fields are latched.
  - `pending_next = (pending & ~grant) | req`.
  - A req while `pending=1` and not granted that cycle is dropped. The buffer keeps the old request and `err` is set.
  - A req in the same cycle as that port's grant is accepted into the freed buffer.
- **Arbitration** occurs in IDLE and DONE states whenever any `pending=1`.
  - One pending: that port wins.
  - Both pending: the port not granted last wins.
  - The `last_gnt` register resets to IF, so data wins the first tie.
  - At the grant edge: `mem_addr`/`mem_we`/`mem_wdata` load from the winner's buffer, the owner is recorded, `last_gnt` is updated, and the winner's `pending` clears.
- **States:**
  - IDLE --grant--> ACCESS.
  - ACCESS: a counter counts MEM_LAT cycles; after the last one, go to DONE.
  - DONE: the owner's done pulse is asserted. Go to ACCESS if a grant is made this cycle, else IDLE.
- **Memory-side outputs:**
  - `mem_we` is high only in the first ACCESS cycle of a store.
  - `mem_addr` and `mem_wdata` are held through ACCESS and keep their last value otherwise.
- **Read data:**
  - For a load or fetch, `mem_rdata` is captured into the owner's rdata register at the edge ending the last ACCESS cycle.
  - A store completes with `d_done`; `d_rdata` is unchanged.
- **Fetch ports:** fetch requests never write; `if_we` is hardwired to 0 internally.
- **Reset, including mid-access:**
  - Takes effect at the next edge: state IDLE, counter 0, both pending 0, `last_gnt` = IF.
  - All outputs go to 0: `mem_addr`, `mem_we`, `mem_wdata`, `if_done`, `d_done`, `if_rdata`, `d_rdata`, `busy`, `err`.
  - The in-flight access is discarded with no done pulse. A store cut off after its first ACCESS cycle has already written.

## Timing
- A req in cycle N is arbitrated in cycle N+1 if the state is IDLE or DONE.
- ACCESS occupies cycles N+2 .. N+1+MEM_LAT; done is asserted in cycle N+2+MEM_LAT.
  - Unloaded latency is MEM_LAT+2 cycles, i.e. 4 cycles at default.
- Back-to-back throughput is one access per MEM_LAT+1 cycles, because arbitration overlaps DONE.
- Worst-case wait for the losing port is one full access plus its own access; there is no starvation.
- `if_done` and `d_done` are never high in the same cycle.

## Structure
- Shared package `cpu_pkg`: `ADDR_W`/`DATA_W` defaults, the state enum {IDLE, ACCESS, DONE}, and port IDs PORT_IF=0, PORT_D=1.
- Sub-module `mem_req_buf`, instantiated twice (fetch and data):
  - holds the pending bit, the latched addr/we/wdata, the accept logic and the overflow flag;
  - takes `grant` as an input.
- The top level holds the arbiter, FSM, latency counter, output registers and the sticky `err` OR.

## Test plan
- **Single fetch:** `if_req` at cycle 0 with `if_addr=0x0010`, memory[0x0010]=0xA5A5, MEM_LAT=2 -> `mem_addr=0x0010` in cycles 2–3, `mem_we=0`, `if_done=1` in cycle 4 with `if_rdata=0xA5A5`.
- **Store then load:** store of 0x1234 to address 0x0040 -> `mem_we=1` only in its first ACCESS cycle, then `d_done`. A load of 0x0040 issued on the `d_done` cycle -> `d_done` after MEM_LAT+2 cycles with `d_rdata=0x1234`.
- **Simultaneous requests:** `if_req` and `d_req` both in cycle 0 after reset -> data served first (`d_done` cycle 4), fetch second (`if_done` cycle 7). Repeated ties alternate IF, D, IF.
- **Overflow:** second `d_req` (addr 0x0050) while an earlier data request is still pending -> `err=1` and stays 1. Only the first address appears on `mem_addr`. Only one `d_done`.
- **Reset mid-access:** `reset` in cycle 3 of a load -> next cycle all outputs 0 and `busy=0`. No `d_done` ever follows. A fresh `if_req` is then served with normal 4-cycle latency.
- **MEM_LAT=1 regression:** back-to-back fetches to 0x0000–0x0003 pending continuously -> `if_done` every 2 cycles with the correct words.
